// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//   Turns an 8-bit intensity into a train of single-cycle spikes over a fixed
//   window of 2^WINDOW_BITS enabled RUN cycles, for driving a LIF neuron input.
//   mode 0: phase accumulator, one spike per carry out of acc + level.
//   mode 1: stochastic, spike when the Galois LFSR value is below level.
//   A refractory counter (REFRAC) drops candidate spikes right after an
//   emitted one.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ena          in   global enable; low freezes every register
//   load         in   start strobe, only honoured in IDLE
//   level[7:0]   in   spike intensity, captured on an accepted load
//   mode         in   0 = accumulator, 1 = LFSR; captured on an accepted load
//   spike_out    out  registered single-cycle spike (masked while ena=0)
//   busy         out  high exactly while in RUN
//   done         out  one-cycle pulse in DONE (masked while ena=0)
//   spike_count  out  spikes emitted in the current/last window, saturating
//   dbg_state_o  out  FSM state for checkers (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a start is accepted on a rising edge where ena=1, load=1 and the
// FSM is in IDLE; load is don't-care in every other state or when ena=0.
module spike_rate_encoder #(
  parameter int          WINDOW_BITS = 8,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int          REFRAC      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] level,
  input  logic       mode,
  output logic       spike_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] spike_count,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0]             REFRAC_V = 4'(REFRAC);
  localparam logic [WINDOW_BITS-1:0] WIN_LAST = '1;
  localparam logic [WINDOW_BITS-1:0] WIN_ONE  = {{(WINDOW_BITS-1){1'b0}}, 1'b1};
  // x^8+x^6+x^5+x^4+1 in right-shifting Galois form
  localparam logic [7:0]             LFSR_TAPS = 8'hB8;

  state_e                 state_q, state_d;
  logic [7:0]             acc_q, acc_d;
  logic [7:0]             lfsr_q, lfsr_d;
  logic [WINDOW_BITS-1:0] win_q, win_d;
  logic [3:0]             refr_q, refr_d;
  logic [7:0]             level_q, level_d;
  logic                   mode_q, mode_d;
  logic                   spike_q, spike_d;
  logic [7:0]             cnt_q, cnt_d;

  logic [8:0] sum;
  logic [7:0] lfsr_next;
  logic       cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 8'd0;
      lfsr_q  <= LFSR_SEED;
      win_q   <= '0;
      refr_q  <= 4'd0;
      level_q <= 8'd0;
      mode_q  <= 1'b0;
      spike_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lfsr_q  <= lfsr_d;
      win_q   <= win_d;
      refr_q  <= refr_d;
      level_q <= level_d;
      mode_q  <= mode_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    lfsr_d    = lfsr_q;
    win_d     = win_q;
    refr_d    = refr_q;
    level_d   = level_q;
    mode_d    = mode_q;
    spike_d   = spike_q;
    cnt_d     = cnt_q;
    sum       = {1'b0, acc_q} + {1'b0, level_q};
    lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    cand      = 1'b0;

    // With ena low nothing moves, including the pending spike bit.
    if (ena) begin
      spike_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            state_d = S_RUN;
            level_d = level;
            mode_d  = mode;
            acc_d   = 8'd0;
            win_d   = '0;
            cnt_d   = 8'd0;
            refr_d  = 4'd0;
            lfsr_d  = LFSR_SEED;
          end
        end
        S_RUN: begin
          if (mode_q) begin
            cand   = (lfsr_q < level_q);
            lfsr_d = lfsr_next;
          end else begin
            cand  = sum[8];
            acc_d = sum[7:0];
          end
          // A candidate arriving while refractory is simply lost; the
          // generator above has already advanced regardless.
          if (refr_q != 4'd0) begin
            refr_d = refr_q - 4'd1;
          end else if (cand) begin
            spike_d = 1'b1;
            refr_d  = REFRAC_V;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
          win_d = win_q + WIN_ONE;
          if (win_q == WIN_LAST) state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign spike_out   = spike_q & ena;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE) & ena;
  assign spike_count = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;

  localparam int N = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, load, mode;
  logic [7:0] level;

  logic       spk0, busy0, done0;
  logic [7:0] cnt0;
  logic [1:0] st0;
  logic       spk3, busy3, done3;
  logic [7:0] cnt3;
  logic [1:0] st3;

  spike_rate_encoder #(.WINDOW_BITS(8), .LFSR_SEED(8'hA5), .REFRAC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .level(level), .mode(mode),
    .spike_out(spk0), .busy(busy0), .done(done0), .spike_count(cnt0), .dbg_state_o(st0)
  );

  spike_rate_encoder #(.WINDOW_BITS(8), .LFSR_SEED(8'hA5), .REFRAC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .level(level), .mode(mode),
    .spike_out(spk3), .busy(busy3), .done(done3), .spike_count(cnt3), .dbg_state_o(st3)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  // expected final counts of each window, popped by the table check
  logic [7:0] exp_q[$];

  // reference spike trains indexed by enabled RUN cycle (1..N); [0] = none
  logic       emit0[0:N];
  logic       emit3[0:N];
  logic [7:0] cum0[0:N];
  logic [7:0] cum3[0:N];
  logic [7:0] last0, last3;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  // Spike trains straight from the rules: deterministic mode emits one spike
  // whenever floor(k*L/256) steps up; stochastic compares the LFSR sequence.
  // The REFRAC=3 train then drops candidates within 3 cycles of a spike.
  task automatic build_model(input logic [7:0] lvl, input logic md);
    logic [7:0] lf;
    int         r3, c0, c3;
    logic       cand;
    lf = 8'hA5; r3 = 0; c0 = 0; c3 = 0;
    emit0[0] = 1'b0; emit3[0] = 1'b0; cum0[0] = 8'd0; cum3[0] = 8'd0;
    for (int k = 1; k <= N; k++) begin
      if (md) begin
        cand = (lf < lvl);
        lf   = lfsr_step(lf);
      end else begin
        cand = ((k * int'(lvl)) / 256) != (((k - 1) * int'(lvl)) / 256);
      end
      emit0[k] = cand;
      if (cand && r3 == 0) begin
        emit3[k] = 1'b1;
        r3 = 3;
      end else begin
        emit3[k] = 1'b0;
        if (r3 > 0) r3--;
      end
      c0 += int'(emit0[k]);
      c3 += int'(emit3[k]);
      cum0[k] = (c0 > 255) ? 8'd255 : 8'(c0);
      cum3[k] = (c3 > 255) ? 8'd255 : 8'(c3);
    end
  endtask

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: busy,done,spike,count got %b,%b,%b,%0d want %b,%b,%b,%0d",
               nm, $time, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic check_both(input string nm, input logic eb, input logic ed,
                            input logic es0, input logic [7:0] ec0,
                            input logic es3, input logic [7:0] ec3);
    chk({nm, "/refrac0"}, {busy0, done0, spk0, cnt0}, {eb, ed, es0, ec0});
    chk({nm, "/refrac3"}, {busy3, done3, spk3, cnt3}, {eb, ed, es3, ec3});
  endtask

  task automatic chk_count(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: spike_count got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left at posedge+1. Inputs change at posedge+1, outputs are
  // checked at posedge+2. abort_at>0 pulls rst_n mid-RUN and returns.
  task automatic do_window(input logic [7:0] lvl, input logic md, input int p_at,
                           input int p_len, input bit rnd, input int abort_at);
    int e, paused;
    build_model(lvl, md);
    ena = 1'b1; load = 1'b1; level = lvl; mode = md;
    #1;
    check_both("idle_load", 1'b0, 1'b0, 1'b0, last0, 1'b0, last3);
    @(posedge clk); #1;
    e = 0; paused = 0;
    while (e < N) begin
      if (abort_at > 0 && e == abort_at) begin
        ena = 1'b1; load = 1'b0;
        #2; rst_n = 1'b0;
        #1;
        check_both("async_reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        @(posedge clk); #1;
        check_both("reset_hold", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        rst_n = 1'b1;
        last0 = 8'd0; last3 = 8'd0;
        @(posedge clk); #1;
        return;
      end
      if (rnd) ena = ($urandom_range(0, 3) != 0);
      else if (p_len > 0 && e == p_at && paused < p_len) begin
        ena = 1'b0;
        paused++;
      end else ena = 1'b1;
      // captured values must be immune to these
      load  = 1'($urandom_range(0, 1));
      level = 8'($urandom_range(0, 255));
      mode  = 1'($urandom_range(0, 1));
      #1;
      check_both("run", 1'b1, 1'b0, ena ? emit0[e] : 1'b0, cum0[e],
                 ena ? emit3[e] : 1'b0, cum3[e]);
      @(posedge clk); #1;
      if (ena) e++;
    end
    load = 1'($urandom_range(0, 1));
    if (rnd && $urandom_range(0, 1) == 1) begin
      ena = 1'b0;
      #1;
      check_both("done_frozen", 1'b0, 1'b0, 1'b0, cum0[N], 1'b0, cum3[N]);
      @(posedge clk); #1;
    end
    ena = 1'b1;
    #1;
    check_both("done", 1'b0, 1'b1, emit0[N], cum0[N], emit3[N], cum3[N]);
    @(posedge clk); #1;
    load = 1'b0;
    #1;
    check_both("idle_after", 1'b0, 1'b0, 1'b0, cum0[N], 1'b0, cum3[N]);
    last0 = cum0[N]; last3 = cum3[N];
    @(posedge clk); #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] lvl;
    logic       md;
    int         p_at;
    int         p_len;
    int         exp0;   // -1: reference model only
    int         exp3;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd64,  1'b0, 0,   0,  64,  64};
    vecs[1] = '{8'd0,   1'b0, 0,   0,  0,   0};
    vecs[2] = '{8'd255, 1'b0, 0,   0,  255, 64};
    vecs[3] = '{8'd64,  1'b0, 100, 10, 64,  64};
    vecs[4] = '{8'd128, 1'b1, 0,   0,  -1,  -1};
    vecs[5] = '{8'd1,   1'b0, 0,   0,  1,   1};
    vecs[6] = '{8'd0,   1'b1, 0,   0,  0,   0};
    vecs[7] = '{8'd128, 1'b0, 37,  5,  128, 64};
    vecs[8] = '{8'd200, 1'b1, 0,   0,  -1,  -1};

    rst_n = 1'b0; ena = 1'b0; load = 1'b0; level = 8'd0; mode = 1'b0;
    last0 = 8'd0; last3 = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_both("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_window(vecs[i].lvl, vecs[i].md, vecs[i].p_at, vecs[i].p_len, 1'b0, 0);
      if (vecs[i].exp0 >= 0) begin
        exp_q.push_back(8'(vecs[i].exp0));
        exp_q.push_back(8'(vecs[i].exp3));
        chk_count($sformatf("table%0d/refrac0", i), cnt0, exp_q.pop_front());
        chk_count($sformatf("table%0d/refrac3", i), cnt3, exp_q.pop_front());
      end
    end

    // reset in the middle of a window, then the LFSR must restart from seed
    do_window(8'd64, 1'b0, 0, 0, 1'b0, 37);
    do_window(8'd128, 1'b1, 0, 0, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      do_window(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, 0, 1'b1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
